branch_resolve_bht: RTL and testbench
=====================================

Name: branch_resolve_bht

Overview:
- Parametrised branch-resolution unit: direction predictor plus resolver for the pipeline.
- Holds a branch history table (BHT) of saturating counters, indexed by PC. The IF stage queries it to get a taken/not-taken prediction.
- The EX stage reports the resolved outcome. The block compares outcome against the prediction, generates flush/redirect and trains the BHT.
- Keeps branch and mispredict performance counters.

Parameters:
- XLEN, 32, address/data width.
- BHT_ENTRIES, 64, number of counters; power of two, ≥2.
- CTR_BITS, 2, saturating counter width, ≥1.
- OFFSET_SHIFT, 1, left shift applied to the immediate to form the byte offset.
- REG_REDIRECT, 0, 0 = redirect same cycle as resolve; 1 = redirect registered, one cycle later.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  IF lookup request
- if_pc  in  XLEN  fetch PC to predict
- if_pred_taken  out  1  prediction for if_pc (combinational)
- ex_branch  in  1  EX holds a conditional branch this cycle
- ex_taken  in  1  resolved outcome
- ex_pred  in  1  prediction carried down the pipe with the instruction
- ex_pc  in  XLEN  branch PC
- ex_imm  in  XLEN  sign-extended immediate
- flush  out  1  kill younger instructions and redirect fetch
- redirect_pc  out  XLEN  correct next PC when flush=1
- bht_update  out  1  pulses the cycle the BHT is written (debug/verification)
- perf_branches  out  PERF_W  resolved branch count
- perf_mispredicts  out  PERF_W  mispredict count

Behaviour:
- Index
  - IDX_W = log2(BHT_ENTRIES).
  - idx = pc[IDX_W+1:2], same rule for lookup and update.
  - if_pred_taken = MSB of bht[idx(if_pc)] when if_valid=1; 0 when if_valid=0.
- Reset (synchronous, while reset=1)
  - Every BHT entry is set to weakly-not-taken: value 2^(CTR_BITS-1)-1, i.e. 01 for CTR_BITS=2. Reset walks all entries in the single reset cycle.
  - perf counters = 0; flush = 0; redirect_pc = 0; bht_update = 0.
  - In REG_REDIRECT=1, the pending redirect register is cleared.
  - Any resolve presented while reset=1 is ignored: no update, no flush, no count.
- Resolution (ex_branch=1, reset=0), decision on {ex_taken, ex_pred}:
  - 00, 11: correct prediction; no flush.
  - 10: flush; redirect_pc = ex_pc + (ex_imm << OFFSET_SHIFT).
  - 01: flush; redirect_pc = ex_pc + 4.
  - Arithmetic is modulo 2^XLEN; wrap past 0xFFFF_FFFF is silent.
- REG_REDIRECT=0: flush and redirect_pc are combinational from EX inputs, valid in the resolve cycle. redirect_pc holds its previous value when flush=0.
- REG_REDIRECT=1: flush and redirect_pc are registered, asserted exactly one cycle after the resolve cycle, for one cycle only.
- BHT training, at the clock edge ending the resolve cycle:
  - ex_taken=1: increment, saturating at 2^CTR_BITS-1.
  - ex_taken=0: decrement, saturating at 0.
  - bht_update=1 is registered and asserted the cycle after each write.
- Perf counters
  - perf_branches +1 per resolve.
  - perf_mispredicts +1 per flush-producing resolve.
  - Both counters wrap at 2^PERF_W.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value (read-before-write). The new value is visible from the next cycle.
- ex_branch=0: no flush, no update, no count, regardless of the other EX inputs.
- Back-to-back resolves are allowed every cycle; each one updates independently.

Decomposition:
- Shared package branch_pkg holds:
  - resolve-code enum (CORRECT_NT, CORRECT_T, MISS_TAKEN, MISS_NOT_TAKEN)
  - counter-init constant function
  - the index-extraction function
- One natural sub-module, sat_counter_update: combinational CTR_BITS-wide saturating increment/decrement.

Test Plan:
- Reset, then lookup if_pc=0x00000040 → if_pred_taken=0; every entry reads 01.
- Resolve pc=0x100, imm=0x10, taken=1, pred=0 → flush=1, redirect_pc=0x120, perf_mispredicts=1; bht[0] → 10; a following lookup of 0x100 predicts taken.
- Resolve pc=0x200, taken=0, pred=1 → flush=1, redirect_pc=0x204.
  - With REG_REDIRECT=1, flush appears exactly one cycle later, for one cycle.
- Four taken resolves at pc=0x300 → counter 01→10→11→11 (saturates); four not-taken resolves → 11→10→01→00→00.
- Same cycle: lookup and update at index 5, counter=01, taken=1 → lookup returns 0; next cycle returns 1.
- Wrap and reset cases:
  - pc=0xFFFFFFF0, imm=0x10, taken=1, pred=0 → redirect_pc=0x00000010.
  - Assert reset during a resolve → no flush, no count, all entries return to 01.

Source files
------------

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared types and helpers for the branch-resolution unit.
//   resolve_e  : outcome of a resolved branch, encoded as {taken, predicted}
//   ctr_init   : weakly-not-taken reset value for a CTR_BITS-wide counter
//   bht_index  : word-aligned PC bits used to index the history table; the
//                caller truncates the result to the table's index width
// -----------------------------------------------------------------------------
package branch_pkg;

  // Encoding matches {ex_taken, ex_pred} so a plain cast classifies a resolve.
  typedef enum logic [1:0] {
    CORRECT_NT     = 2'b00,
    MISS_NOT_TAKEN = 2'b01,
    MISS_TAKEN     = 2'b10,
    CORRECT_T      = 2'b11
  } resolve_e;

  // Weakly-not-taken: 2^(ctr_bits-1) - 1 (01 for a 2-bit counter, 0 for 1-bit).
  function automatic int unsigned ctr_init(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
  endfunction

  // Drops the two byte-offset bits; the low IDX_W bits of the result are
  // pc[IDX_W+1:2]. Lookup and training both go through here so they agree.
  function automatic logic [63:0] bht_index(input logic [63:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// -----------------------------------------------------------------------------
// sat_counter_update
// Combinational next value of a saturating up/down counter.
//   ctr_i : current counter value (CTR_BITS)
//   inc_i : 1 = count up (branch taken), 0 = count down (not taken)
//   ctr_o : next counter value, clamped at all-ones and at zero
// -----------------------------------------------------------------------------
module sat_counter_update #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                inc_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != CTR_MAX) begin
        ctr_o = ctr_i + CTR_BITS'(1);
      end
    end else begin
      if (ctr_i != CTR_MIN) begin
        ctr_o = ctr_i - CTR_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// branch_resolve_bht
// Branch direction predictor (table of saturating counters indexed by PC)
// plus the EX-stage resolver that produces flush/redirect and trains the table.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   if_valid, if_pc   : IF lookup request and fetch PC
//   if_pred_taken     : combinational prediction for if_pc (0 when !if_valid)
//   ex_branch         : EX holds a conditional branch this cycle
//   ex_taken, ex_pred : resolved outcome and the prediction it was fetched with
//   ex_pc, ex_imm     : branch PC and sign-extended immediate
//   flush             : kill younger instructions, fetch from redirect_pc
//   redirect_pc       : corrected next PC (holds its last value otherwise)
//   bht_update        : high the cycle after each table write
//   perf_branches     : count of resolved branches (wraps)
//   perf_mispredicts  : count of mispredicted branches (wraps)
// -----------------------------------------------------------------------------
module branch_resolve_bht
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int CTR_BITS     = 2,
  parameter int OFFSET_SHIFT = 1,
  parameter int REG_REDIRECT = 0,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_branch,
  input  logic              ex_taken,
  input  logic              ex_pred,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_imm,
  output logic              flush,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              bht_update,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int                  IDX_W    = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

  // Counter table. Kept in flops rather than RAM: the whole table must return
  // to weakly-not-taken in a single reset cycle and the IF read is same-cycle.
  logic [CTR_BITS-1:0] bht_q [BHT_ENTRIES];

  logic [IDX_W-1:0]    if_idx;
  logic [IDX_W-1:0]    ex_idx;
  logic [CTR_BITS-1:0] if_ctr;
  logic [CTR_BITS-1:0] ex_ctr;
  logic [CTR_BITS-1:0] ex_ctr_d;

  resolve_e            code;
  logic                resolve;
  logic                mispredict;
  logic [XLEN-1:0]     taken_target;
  logic [XLEN-1:0]     fall_target;
  logic [XLEN-1:0]     target;

  logic [XLEN-1:0]     redirect_q;
  logic [XLEN-1:0]     redirect_d;
  logic                bht_update_q;
  logic [PERF_W-1:0]   perf_branches_q;
  logic [PERF_W-1:0]   perf_mispredicts_q;

  // ---------------------------------------------------------------------------
  // Lookup (IF). Reads the registered table, so a same-cycle update to the
  // same entry is not yet visible: read-before-write falls out naturally.
  // ---------------------------------------------------------------------------
  assign if_idx        = IDX_W'(bht_index(64'(if_pc)));
  assign if_ctr        = bht_q[if_idx];
  assign if_pred_taken = if_valid & if_ctr[CTR_BITS-1];

  // ---------------------------------------------------------------------------
  // Resolution (EX)
  // ---------------------------------------------------------------------------
  assign ex_idx = IDX_W'(bht_index(64'(ex_pc)));
  assign ex_ctr = bht_q[ex_idx];

  always_comb begin
    code       = resolve_e'({ex_taken, ex_pred});
    // A resolve during reset is dropped entirely.
    resolve    = ex_branch & ~reset;
    mispredict = resolve && ((code == MISS_TAKEN) || (code == MISS_NOT_TAKEN));
  end

  // Both targets wrap modulo 2^XLEN by construction of the XLEN-wide adders.
  assign taken_target = ex_pc + (ex_imm << OFFSET_SHIFT);
  assign fall_target  = ex_pc + XLEN'(4);
  assign target       = (code == MISS_TAKEN) ? taken_target : fall_target;
  assign redirect_d   = mispredict ? target : redirect_q;

  sat_counter_update #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter_update (
    .ctr_i (ex_ctr),
    .inc_i (ex_taken),
    .ctr_o (ex_ctr_d)
  );

  // ---------------------------------------------------------------------------
  // Flush / redirect presentation
  // ---------------------------------------------------------------------------
  generate
    if (REG_REDIRECT != 0) begin : g_reg_redirect
      // One-cycle-late pulse; redirect_q already holds the matching target.
      logic flush_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          flush_q <= 1'b0;
        end else begin
          flush_q <= mispredict;
        end
      end

      assign flush       = flush_q & ~reset;
      assign redirect_pc = reset ? '0 : redirect_q;
    end else begin : g_comb_redirect
      // redirect_d equals redirect_q whenever there is no mispredict, which
      // gives the hold-last-value behaviour on the output.
      assign flush       = mispredict;
      assign redirect_pc = reset ? '0 : redirect_d;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else if (resolve) begin
      bht_q[ex_idx] <= ex_ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_q         <= '0;
      bht_update_q       <= 1'b0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      redirect_q   <= redirect_d;
      bht_update_q <= resolve;
      if (resolve) begin
        perf_branches_q <= perf_branches_q + PERF_W'(1);
      end
      if (mispredict) begin
        perf_mispredicts_q <= perf_mispredicts_q + PERF_W'(1);
      end
    end
  end

  assign bht_update       = bht_update_q;
  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_bht
// Table-driven bench for branch_resolve_bht. Each table row is one cycle of
// stimulus with its expected prediction and flush/redirect. Expected
// flush/redirect records go into a scoreboard queue when a row is driven and
// are popped when the DUT presents them (same cycle, or one cycle later when
// REG_REDIRECT=1). Perf counters and bht_update are checked after each edge.
// -----------------------------------------------------------------------------
module tb_branch_resolve_bht;

  parameter int REG_REDIRECT = 0;
  localparam int LAT = (REG_REDIRECT != 0) ? 1 : 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_branch;
  logic        ex_taken;
  logic        ex_pred;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        bht_update;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  branch_resolve_bht #(
    .XLEN         (32),
    .BHT_ENTRIES  (64),
    .CTR_BITS     (2),
    .OFFSET_SHIFT (1),
    .REG_REDIRECT (REG_REDIRECT),
    .PERF_W       (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_branch        (ex_branch),
    .ex_taken         (ex_taken),
    .ex_pred          (ex_pred),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .bht_update       (bht_update),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        tk;
    logic        pd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        lv;
    logic [31:0] lpc;
    logic        e_pred;
    logic        e_fl;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    logic        fl;
    logic [31:0] rd;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_br     = 0;
  int unsigned m_mp     = 0;
  logic [31:0] m_rd     = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic br, input logic tk, input logic pd,
                     input logic [31:0] pc, input logic [31:0] imm,
                     input logic lv, input logic [31:0] lpc, input logic e_pred,
                     input logic e_fl, input logic [31:0] e_rd);
    vec_t v;
    v.br = br; v.tk = tk; v.pd = pd; v.pc = pc; v.imm = imm;
    v.lv = lv; v.lpc = lpc; v.e_pred = e_pred; v.e_fl = e_fl; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  // One cycle: drive just after a rising edge, sample mid-cycle, then check
  // the registered side effects just after the next rising edge.
  task automatic step(input string tag, input logic rs, input logic br, input logic tk,
                      input logic pd, input logic [31:0] pc, input logic [31:0] imm,
                      input logic lv, input logic [31:0] lpc, input logic e_pred,
                      input logic e_fl, input logic [31:0] e_rd);
    exp_t e;
    reset     = rs;
    ex_branch = br;
    ex_taken  = tk;
    ex_pred   = pd;
    ex_pc     = pc;
    ex_imm    = imm;
    if_valid  = lv;
    if_pc     = lpc;
    if (rs) begin
      sb.delete();
    end else begin
      e.fl = e_fl;
      e.rd = e_rd;
      sb.push_back(e);
    end
    #4;
    $display("%s: rst=%0b br=%0b tk=%0b pd=%0b pc=%08h lv=%0b lpc=%08h -> pred=%0b flush=%0b redirect=%08h",
             tag, rs, br, tk, pd, pc, lv, lpc, if_pred_taken, flush, redirect_pc);
    if (rs) begin
      chk({tag, ".flush_in_reset"}, 32'(flush), 32'h0);
      chk({tag, ".redirect_in_reset"}, redirect_pc, 32'h0);
    end else begin
      chk({tag, ".pred"}, 32'(if_pred_taken), 32'(e_pred));
      if (sb.size() > LAT) begin
        e = sb.pop_front();
        if (e.fl) m_rd = e.rd;
        chk({tag, ".flush"}, 32'(flush), 32'(e.fl));
        chk({tag, ".redirect_pc"}, redirect_pc, m_rd);
      end
    end
    @(posedge clk);
    #1;
    if (rs) begin
      m_br = 0;
      m_mp = 0;
      m_rd = 32'h0;
    end else begin
      if (br) m_br++;
      if (br && e_fl) m_mp++;
    end
    chk({tag, ".bht_update"}, 32'(bht_update), 32'(br & ~rs));
    chk({tag, ".perf_branches"}, perf_branches, m_br);
    chk({tag, ".perf_mispredicts"}, perf_mispredicts, m_mp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_pc = '0; ex_branch = 1'b0;
    ex_taken = 1'b0; ex_pred = 1'b0; ex_pc = '0; ex_imm = '0;

    // Index of a PC is pc[7:2]; 0x100, 0x200, 0x300, 0x400, 0x500, 0x1000 all
    // alias to entry 0, 0x14/0x114 to entry 5, 0xFFFFFFF0 to 60, 0xFFFFFFFC to 63.
    //   br  tk  pd  pc            imm           lv  lpc           pred fl  redirect
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'h40,       0,   0,  32'h0);        // reset value 01
    add(1,  1,  0,  32'h100,      32'h10,       1,  32'h100,      0,   1,  32'h120);      // miss taken; e0 01->10
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'h100,      1,   0,  32'h0);
    add(1,  0,  1,  32'h200,      32'h40,       1,  32'h200,      1,   1,  32'h204);      // miss not taken; e0 10->01
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'h200,      0,   0,  32'h0);
    add(1,  1,  1,  32'h300,      32'h8,        1,  32'h300,      0,   0,  32'h0);        // 01->10
    add(1,  1,  1,  32'h300,      32'h8,        1,  32'h300,      1,   0,  32'h0);        // 10->11
    add(1,  1,  1,  32'h300,      32'h8,        1,  32'h300,      1,   0,  32'h0);        // 11->11
    add(1,  1,  1,  32'h300,      32'h8,        1,  32'h300,      1,   0,  32'h0);        // 11->11
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'h300,      1,   0,  32'h0);
    add(0,  0,  0,  32'h0,        32'h0,        0,  32'h300,      0,   0,  32'h0);        // if_valid=0 masks
    add(1,  0,  0,  32'h300,      32'h8,        1,  32'h300,      1,   0,  32'h0);        // 11->10
    add(1,  0,  0,  32'h300,      32'h8,        1,  32'h300,      1,   0,  32'h0);        // 10->01
    add(1,  0,  0,  32'h300,      32'h8,        1,  32'h300,      0,   0,  32'h0);        // 01->00
    add(1,  0,  0,  32'h300,      32'h8,        1,  32'h300,      0,   0,  32'h0);        // 00->00
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'h300,      0,   0,  32'h0);
    add(1,  1,  0,  32'h14,       32'h8,        1,  32'h14,       0,   1,  32'h24);       // same-cycle read sees 01
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'h14,       1,   0,  32'h0);        // now 10
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'h114,      1,   0,  32'h0);        // alias of entry 5
    add(0,  1,  0,  32'h14,       32'h8,        1,  32'h14,       1,   0,  32'h0);        // ex_branch=0 ignored
    add(1,  0,  0,  32'h14,       32'h8,        1,  32'h14,       1,   0,  32'h0);        // 10->01
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'h14,       0,   0,  32'h0);
    add(1,  1,  0,  32'hFFFFFFF0, 32'h10,       0,  32'h0,        0,   1,  32'h00000010); // wraps past zero
    add(1,  1,  0,  32'h1000,     32'hFFFFFFF8, 0,  32'h0,        0,   1,  32'h00000FF0); // negative imm
    add(1,  0,  1,  32'hFFFFFFFC, 32'h0,        0,  32'h0,        0,   1,  32'h00000000); // pc+4 wraps
    add(1,  1,  0,  32'h400,      32'h4,        1,  32'h0,        0,   1,  32'h408);      // back-to-back miss
    add(1,  0,  1,  32'h500,      32'h0,        1,  32'h0,        1,   1,  32'h504);      // back-to-back miss
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'hFFFFFFF0, 1,   0,  32'h0);        // e60 is 10
    add(0,  0,  0,  32'h0,        32'h0,        1,  32'hFC,       0,   0,  32'h0);        // e63 is 00
    add(0,  0,  0,  32'h0,        32'h0,        0,  32'h0,        0,   0,  32'h0);
    add(0,  0,  0,  32'h0,        32'h0,        0,  32'h0,        0,   0,  32'h0);

    @(posedge clk);
    #1;
    step("reset0", 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    step("reset1", 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

    foreach (vecs[k]) begin
      step($sformatf("vec%0d", k), 0, vecs[k].br, vecs[k].tk, vecs[k].pd, vecs[k].pc,
           vecs[k].imm, vecs[k].lv, vecs[k].lpc, vecs[k].e_pred, vecs[k].e_fl, vecs[k].e_rd);
    end

    // Reset asserted while a mispredicting resolve is presented: it must be
    // dropped (no flush now or later, no count) and every entry back to 01.
    step("rst_resolve", 1, 1, 1, 0, 32'h100, 32'h10, 0, 32'h0, 0, 1, 32'h120);
    step("post_rst0", 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h100, 0, 0, 32'h0);
    step("post_rst1", 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hFFFFFFF0, 0, 0, 32'h0);

    // Every entry must hold exactly 01: one correct taken resolve (with a
    // same-cycle lookup reading the old value) must flip it to predict taken.
    for (int i = 0; i < 64; i++) begin
      step($sformatf("walk%0d_upd", i), 0, 1, 1, 1, 32'(i * 4), 32'h0, 1, 32'(i * 4), 0, 0, 32'h0);
      step($sformatf("walk%0d_chk", i), 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'(i * 4), 1, 0, 32'h0);
    end

    step("drain0", 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    step("drain1", 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
